// File: rtl/disp_pkg.sv
// disp_pkg: shared constants and types for the display scanner.
//   NUM_SLOTS      - scan slots per frame (six digits plus one annunciator slot)
//   SLOT_*         - slot indices in scan order
//   ANN_*          - bit positions of the annunciators on the segment bus
//   slot_t         - slot index type
//   snap_t         - one frame's worth of captured display inputs
//   slot_onehot()  - digit-enable pattern for a slot
package disp_pkg;

  localparam int NUM_SLOTS = 7;

  typedef logic [2:0] slot_t;

  localparam slot_t SLOT_U10   = 3'd0;
  localparam slot_t SLOT_U01   = 3'd1;
  localparam slot_t SLOT_L1000 = 3'd2;
  localparam slot_t SLOT_L0100 = 3'd3;
  localparam slot_t SLOT_L0010 = 3'd4;
  localparam slot_t SLOT_L0001 = 3'd5;
  localparam slot_t SLOT_ANN   = 3'd6;

  localparam int ANN_AVS   = 0;
  localparam int ANN_DAY   = 1;
  localparam int ANN_MAX   = 2;
  localparam int ANN_TIM   = 3;
  localparam int ANN_COL   = 4;
  localparam int ANN_POINT = 5;

  typedef struct packed {
    logic [7:0] u10;
    logic [7:0] u01;
    logic [7:0] l1000;
    logic [7:0] l0100;
    logic [7:0] l0010;
    logic [7:0] l0001;
    logic [5:0] ann;
  } snap_t;

  function automatic logic [6:0] slot_onehot(input slot_t s);
    return 7'd1 << s;
  endfunction

endpackage

// File: rtl/disp_slot_timer.sv
// disp_slot_timer: dwell counter and slot sequencer for the display scanner.
// Optional macro DISP_BRIGHTNESS_EN exposes the dwell counter so the parent
// can shorten the lit window.
// Ports:
//   clock      in   system clock
//   reset      in   synchronous, active-high
//   slot       out  current scan slot (0..6)
//   frame_tick out  high while slot==0 and tick==0 (first cycle of a frame)
//   blank      out  high during the first BLANK_CYCLES cycles of each slot
//   tick       out  dwell counter (only with DISP_BRIGHTNESS_EN)
module disp_slot_timer
  import disp_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 8,
  parameter int TICK_W       = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1
) (
  input  logic              clock,
  input  logic              reset,
  output slot_t             slot,
  output logic              frame_tick,
  output logic              blank
`ifdef DISP_BRIGHTNESS_EN
  ,
  output logic [TICK_W-1:0] tick
`endif
);

  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(DWELL_CYCLES - 1);
  localparam logic [TICK_W-1:0] BLANK_T   = TICK_W'(BLANK_CYCLES);

  logic [TICK_W-1:0] tick_r;
  slot_t             slot_r;

  // Dwell counter wraps every DWELL_CYCLES; each wrap advances the slot 0..6.
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_r <= '0;
      slot_r <= SLOT_U10;
    end else if (tick_r == LAST_TICK) begin
      tick_r <= '0;
      slot_r <= (slot_r == SLOT_ANN) ? SLOT_U10 : slot_r + 3'd1;
    end else begin
      tick_r <= tick_r + TICK_W'(1);
      slot_r <= slot_r;
    end
  end

  assign slot       = slot_r;
  assign frame_tick = (slot_r == SLOT_U10) && (tick_r == '0);
  assign blank      = (tick_r < BLANK_T);
`ifdef DISP_BRIGHTNESS_EN
  assign tick       = tick_r;
`endif

endmodule

// File: rtl/disp_scan.sv
// disp_scan: frame-snapshotting, time-multiplexed display driver.
// Captures all digit patterns and annunciators once per frame and scans them
// onto a shared segment bus with one-hot digit enables and a blanking gap at
// each slot change.
// Optional macro DISP_BRIGHTNESS_EN adds a 2-bit bright input that limits the
// lit window to ((DWELL_CYCLES-BLANK_CYCLES)*(bright+1))/4 cycles per slot.
// Ports:
//   clock, reset                     clock and synchronous active-high reset
//   upper10..lower0001 [7:0]         segment patterns {dp,g..a}
//   AVS, DAY, MAX, TIM, col, point   annunciator requests
//   bright [1:0]                     brightness (only with DISP_BRIGHTNESS_EN)
//   seg [7:0]                        shared segment bus (registered)
//   dig_en [6:0]                     one-hot slot enable, bit 6 = annunciators
//   frame_start                      one-cycle pulse after the snapshot loads
module disp_scan
  import disp_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] upper10,
  input  logic [7:0] upper01,
  input  logic [7:0] lower1000,
  input  logic [7:0] lower0100,
  input  logic [7:0] lower0010,
  input  logic [7:0] lower0001,
  input  logic       AVS,
  input  logic       DAY,
  input  logic       MAX,
  input  logic       TIM,
  input  logic       col,
  input  logic       point,
`ifdef DISP_BRIGHTNESS_EN
  input  logic [1:0] bright,
`endif
  output logic [7:0] seg,
  output logic [6:0] dig_en,
  output logic       frame_start
);

  localparam int TICK_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  slot_t      slot_s;
  logic       frame_tick_s;
  logic       blank_s;
  snap_t      snap_r;
  snap_t      snap_in_s;
  snap_t      snap_next_s;
  logic       lit_s;
  logic [7:0] seg_r;
  logic [7:0] seg_next_s;
  logic [6:0] dig_en_r;
  logic [6:0] en_next_s;
  logic       frame_start_r;

`ifdef DISP_BRIGHTNESS_EN
  localparam logic [31:0] LIT_SPAN = 32'(DWELL_CYCLES - BLANK_CYCLES);
  logic [TICK_W-1:0] tick_s;
  logic [1:0]        bright_r;
  logic [1:0]        bright_next_s;
  logic [31:0]       on_len_s;
  logic [31:0]       offset_s;
`endif

  disp_slot_timer #(
    .DWELL_CYCLES(DWELL_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES),
    .TICK_W      (TICK_W)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .slot      (slot_s),
    .frame_tick(frame_tick_s),
    .blank     (blank_s)
`ifdef DISP_BRIGHTNESS_EN
    ,
    .tick      (tick_s)
`endif
  );

  // Gather the live inputs into snapshot layout.
  always_comb begin
    snap_in_s                = '0;
    snap_in_s.u10            = upper10;
    snap_in_s.u01            = upper01;
    snap_in_s.l1000          = lower1000;
    snap_in_s.l0100          = lower0100;
    snap_in_s.l0010          = lower0010;
    snap_in_s.l0001          = lower0001;
    snap_in_s.ann[ANN_AVS]   = AVS;
    snap_in_s.ann[ANN_DAY]   = DAY;
    snap_in_s.ann[ANN_MAX]   = MAX;
    snap_in_s.ann[ANN_TIM]   = TIM;
    snap_in_s.ann[ANN_COL]   = col;
    snap_in_s.ann[ANN_POINT] = point;
  end

  // The output stage uses the values being captured on the frame-start edge,
  // so even with no blanking the first lit cycle of a frame is never stale.
  always_comb begin
    snap_next_s = snap_r;
`ifdef DISP_BRIGHTNESS_EN
    bright_next_s = bright_r;
`endif
    if (frame_tick_s) begin
      snap_next_s = snap_in_s;
`ifdef DISP_BRIGHTNESS_EN
      bright_next_s = bright;
`endif
    end else begin
      snap_next_s = snap_r;
`ifdef DISP_BRIGHTNESS_EN
      bright_next_s = bright_r;
`endif
    end
  end

  // Lit window: after the blanking gap, optionally cut short by brightness.
  always_comb begin
    lit_s = 1'b0;
`ifdef DISP_BRIGHTNESS_EN
    on_len_s = (LIT_SPAN * (32'(bright_next_s) + 32'd1)) >> 2;
    offset_s = 32'(tick_s) - 32'(BLANK_CYCLES);
    if (blank_s) begin
      lit_s = 1'b0;
    end else begin
      lit_s = (offset_s < on_len_s);
    end
`else
    if (blank_s) begin
      lit_s = 1'b0;
    end else begin
      lit_s = 1'b1;
    end
`endif
  end

  // Segment/enable selection for the current slot.
  always_comb begin
    seg_next_s = '0;
    en_next_s  = '0;
    if (lit_s) begin
      en_next_s = slot_onehot(slot_s);
      case (slot_s)
        SLOT_U10:   seg_next_s = snap_next_s.u10;
        SLOT_U01:   seg_next_s = snap_next_s.u01;
        SLOT_L1000: seg_next_s = snap_next_s.l1000;
        SLOT_L0100: seg_next_s = snap_next_s.l0100;
        SLOT_L0010: seg_next_s = snap_next_s.l0010;
        SLOT_L0001: seg_next_s = snap_next_s.l0001;
        SLOT_ANN:   seg_next_s = {2'b00, snap_next_s.ann};
        default: begin
          seg_next_s = '0;
          en_next_s  = '0;
        end
      endcase
    end else begin
      seg_next_s = '0;
      en_next_s  = '0;
    end
  end

  // Snapshot and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      snap_r        <= '0;
      seg_r         <= '0;
      dig_en_r      <= '0;
      frame_start_r <= 1'b0;
`ifdef DISP_BRIGHTNESS_EN
      bright_r      <= 2'd0;
`endif
    end else begin
      snap_r        <= snap_next_s;
      seg_r         <= seg_next_s;
      dig_en_r      <= en_next_s;
      frame_start_r <= frame_tick_s;
`ifdef DISP_BRIGHTNESS_EN
      bright_r      <= bright_next_s;
`endif
    end
  end

  assign seg         = seg_r;
  assign dig_en      = dig_en_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_disp_scan.sv
// tb_disp_scan: scoreboard bench for disp_scan. Expected per-slot segment
// values and lit-cycle counts are queued when inputs are driven and compared
// when a full frame of DUT output has been observed.
module tb_disp_scan;

  localparam int DWELL = 100;
  localparam int BLANK = 8;
  localparam int FRAME = 7 * DWELL;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] upper10 = 8'h00, upper01 = 8'h00, lower1000 = 8'h00;
  logic [7:0] lower0100 = 8'h00, lower0010 = 8'h00, lower0001 = 8'h00;
  logic       AVS = 1'b0, DAY = 1'b0, MAX = 1'b0, TIM = 1'b0, col = 1'b0, point = 1'b0;
`ifdef DISP_BRIGHTNESS_EN
  logic [1:0] bright = 2'd3;
`endif
  logic [7:0] seg;
  logic [6:0] dig_en;
  logic       frame_start;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] seg;
    int         lit;
  } exp_t;
  exp_t sb[$];

  disp_scan #(
    .DWELL_CYCLES(DWELL),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .upper10    (upper10),
    .upper01    (upper01),
    .lower1000  (lower1000),
    .lower0100  (lower0100),
    .lower0010  (lower0010),
    .lower0001  (lower0001),
    .AVS        (AVS),
    .DAY        (DAY),
    .MAX        (MAX),
    .TIM        (TIM),
    .col        (col),
    .point      (point),
`ifdef DISP_BRIGHTNESS_EN
    .bright     (bright),
`endif
    .seg        (seg),
    .dig_en     (dig_en),
    .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  // dig_en must never be multi-hot, and seg must be dark when no enable is on.
  always @(negedge clock) begin
    checks++;
    if (!$onehot0(dig_en) || (dig_en === 7'd0 && seg !== 8'h00)) begin
      errors++;
      $display("FAIL onehot0 t=%0t dig_en=%b seg=%h required onehot0 and dark seg", $time, dig_en, seg);
    end
  end

  function automatic logic [7:0] model_seg(input int s);
    case (s)
      0:       return upper10;
      1:       return upper01;
      2:       return lower1000;
      3:       return lower0100;
      4:       return lower0010;
      5:       return lower0001;
      6:       return {2'b00, point, col, TIM, MAX, DAY, AVS};
      default: return 8'h00;
    endcase
  endfunction

  function automatic int model_lit();
`ifdef DISP_BRIGHTNESS_EN
    return ((DWELL - BLANK) * (int'(bright) + 1)) / 4;
`else
    return DWELL - BLANK;
`endif
  endfunction

  task automatic push_frame();
    for (int s = 0; s < 7; s++) begin
      exp_t e;
      e.seg = model_seg(s);
      e.lit = model_lit();
      sb.push_back(e);
    end
  endtask

  // Observe one frame starting at a frame_start cycle; optionally change
  // upper01 at cycle chg_at of the frame. Called and returns at a negedge.
  task automatic collect_frame(input string name, input bit allow_now,
                               input int chg_at, input logic [7:0] chg_val);
    int         cnt[7];
    logic [7:0] sv[7];
    bit         segbad[7];
    bit         order_bad;
    string      order_msg;
    int         budget;
    int         s;
    int         off;
    exp_t       e;
    budget    = 0;
    order_bad = 1'b0;
    order_msg = "";
    for (int k = 0; k < 7; k++) begin
      cnt[k]    = 0;
      sv[k]     = 8'h00;
      segbad[k] = 1'b0;
    end
    if (!allow_now) begin
      while (frame_start === 1'b1 && budget < 2 * FRAME) begin
        @(negedge clock);
        budget++;
      end
    end
    while (frame_start !== 1'b1 && budget < 3 * FRAME) begin
      @(negedge clock);
      budget++;
    end
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL %s frame_start_wait got=%b required=1 within %0d cycles", name, frame_start, 3 * FRAME);
      return;
    end
    for (int i = 0; i < FRAME; i++) begin
      if (i == chg_at) upper01 = chg_val;
      s   = i / DWELL;
      off = i % DWELL;
      if (dig_en !== 7'd0) begin
        if (!order_bad && (dig_en !== 7'(1 << s) || off < BLANK)) begin
          order_bad = 1'b1;
          $sformat(order_msg, "cycle=%0d dig_en=%b required=%b lit only from offset %0d", i, dig_en, 7'(1 << s), BLANK);
        end
        if (dig_en === 7'(1 << s)) begin
          cnt[s]++;
          if (cnt[s] == 1) sv[s] = seg;
          else if (seg !== sv[s]) segbad[s] = 1'b1;
        end
      end
      if (i > 0 && frame_start !== 1'b0 && !order_bad) begin
        order_bad = 1'b1;
        $sformat(order_msg, "cycle=%0d frame_start=%b required=0", i, frame_start);
      end
      @(negedge clock);
    end
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL %s frame_period got frame_start=%b required=1 after %0d cycles", name, frame_start, FRAME);
    end
    checks++;
    if (order_bad) begin
      errors++;
      $display("FAIL %s scan_order %s", name, order_msg);
    end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s scoreboard_empty slot=%0d", name, k);
      end else begin
        e = sb.pop_front();
        if (segbad[k] || sv[k] !== e.seg) begin
          errors++;
          $display("FAIL %s seg slot=%0d got=%h unstable=%0d required=%h", name, k, sv[k], segbad[k], e.seg);
        end
        checks++;
        if (cnt[k] != e.lit) begin
          errors++;
          $display("FAIL %s lit_cycles slot=%0d got=%0d required=%0d", name, k, cnt[k], e.lit);
        end
      end
    end
  endtask

  task automatic test_reset();
    int cnt;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      checks++;
      if (seg !== 8'h00 || dig_en !== 7'd0 || frame_start !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold seg=%h dig_en=%b fs=%b required all 0", seg, dig_en, frame_start);
      end
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL reset_release frame_start got=%b required=1", frame_start);
    end
    cnt = 1;
    while (dig_en === 7'd0 && cnt < DWELL) begin
      @(negedge clock);
      cnt++;
    end
    checks++;
    if (cnt != BLANK + 1 || dig_en !== 7'b0000001) begin
      errors++;
      $display("FAIL first_enable got cycle=%0d dig_en=%b required cycle=%0d dig_en=0000001", cnt, dig_en, BLANK + 1);
    end
  endtask

  task automatic test_digits();
    upper10   = 8'h3F;
    lower0001 = 8'h06;
    push_frame();
    collect_frame("digits", 1'b0, -1, 8'h00);
  endtask

  task automatic test_annunciator();
    AVS   = 1'b1;
    col   = 1'b1;
    point = 1'b1;
    push_frame();
    collect_frame("annunciator", 1'b0, -1, 8'h00);
  endtask

  task automatic test_midframe();
    upper01 = 8'h5B;
    push_frame();
    collect_frame("midframe_old", 1'b0, DWELL / 2, 8'h4F);
    push_frame();
    collect_frame("midframe_new", 1'b1, -1, 8'h00);
  endtask

  task automatic test_reset_mid();
    int budget;
    lower0010 = 8'h66;
    budget = 0;
    while (dig_en !== 7'b0010000 && budget < 2 * FRAME) begin
      @(negedge clock);
      budget++;
    end
    checks++;
    if (dig_en !== 7'b0010000) begin
      errors++;
      $display("FAIL reset_mid slot4_wait got dig_en=%b required=0010000", dig_en);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (seg !== 8'h00 || dig_en !== 7'd0 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid outputs seg=%h dig_en=%b fs=%b required all 0", seg, dig_en, frame_start);
    end
    repeat (5) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid restart frame_start got=%b required=1", frame_start);
    end
    push_frame();
    collect_frame("reset_mid_frame", 1'b1, -1, 8'h00);
  endtask

`ifdef DISP_BRIGHTNESS_EN
  task automatic test_brightness();
    bright = 2'd0;
    push_frame();
    collect_frame("bright0", 1'b0, -1, 8'h00);
    bright = 2'd3;
    push_frame();
    collect_frame("bright3", 1'b0, -1, 8'h00);
  endtask
`endif

  initial begin
    test_reset();
    test_digits();
    test_annunciator();
    test_midframe();
    test_reset_mid();
`ifdef DISP_BRIGHTNESS_EN
    test_brightness();
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
